// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_pkg
// Purpose  : Shared SHA-256 types and constants: chaining state, message
//            block, initial hash value and block geometry.
// Revision : 1.0  initial release
// ============================================================================
package sha_pkg;

   localparam int BLOCK_WORDS = 16;
   localparam int WORD_W      = 32;
   localparam int CNT_W       = 4;

   // Eight 32-bit chaining words; index 0 is H0 (a).
   typedef logic [7:0][WORD_W-1:0] HashState;

   // Sixteen 32-bit message words; index 0 is the first word received.
   typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] MsgBlock;

   // FIPS 180-4 initial hash value, H7 first so that element [0] is H0.
   localparam HashState SHA256_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

endpackage : sha_pkg
`default_nettype wire

// File: rtl/sha_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : sha_word_assembler
// Purpose  : Captures accepted message words into a 16-slot assembly buffer
//            and counts them. Also latches the per-block first flag and the
//            midstate offered with word 0, and flags acceptance of word 15.
// Revision : 1.0  initial release
// ============================================================================
module sha_word_assembler
   import sha_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic                 i_abort,
   input  logic [WORD_W-1:0]    i_word,
   input  logic                 i_first,
   input  HashState             i_midstate,
   output logic [CNT_W-1:0]     o_count,
   output MsgBlock              o_buf,
   output logic                 o_last,
   output logic                 o_first,
   output HashState             o_midstate
);

   localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

   logic [CNT_W-1:0] r_count;
   MsgBlock          r_buf;
   logic             r_first;
   HashState         r_mid;

   // Abort outranks a word presented in the same cycle, so the word is lost.
   logic w_store;
   assign w_store = i_we & ~i_abort;

   // Word storage, wrapping slot counter and block-start attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_buf   <= '0;
         r_first <= 1'b0;
         r_mid   <= SHA256_IV;
      end else if (i_abort) begin
         r_count <= '0;
      end else if (w_store) begin
         r_buf[r_count] <= i_word;
         r_count        <= r_count + 4'd1;
         if (r_count == '0) begin
            r_first <= i_first;
            if (i_first) begin
               r_mid <= i_midstate;
            end
         end
      end
   end

   assign o_count    = r_count;
   assign o_buf      = r_buf;
   assign o_last     = w_store & (r_count == c_LAST_WORD);
   assign o_first    = r_first;
   assign o_midstate = r_mid;

endmodule : sha_word_assembler
`default_nettype wire

// File: rtl/sha_block_injector.sv
`default_nettype none
// ============================================================================
// Module   : sha_block_injector
// Purpose  : Assembles 32-bit message words into 512-bit blocks and issues
//            each completed block with its chaining state to the round
//            pipeline as a one-cycle valid_o pulse. A gap counter enforces
//            MIN_GAP idle cycles before the next block may start.
// Options  : SHA_INJECT_DOUBLE_BUFFER_EN - separate output block register,
//            word_ready_o stays high in the issue cycle (16-cycle period).
//            Undefined: assembly buffer drives W_o, 17-cycle period.
// Revision : 1.0  initial release
// ============================================================================
module sha_block_injector
   import sha_pkg::*;
#(
   parameter int unsigned MIN_GAP = 0
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  HashState             midstate_i,
   input  logic [WORD_W-1:0]    word_i,
   input  logic                 word_valid_i,
   output logic                 word_ready_o,
   input  logic                 first_i,
   input  logic                 abort_i,
   output HashState             state_o,
   output MsgBlock              W_o,
   output logic                 valid_o,
   output logic                 newblock_o
);

   localparam logic [CNT_W-1:0] c_GAP_LOAD = CNT_W'(MIN_GAP);

   logic [CNT_W-1:0] w_count;
   MsgBlock          w_buf;
   logic             w_last;
   logic             w_first;
   HashState         w_mid;
   logic             w_accept;
   logic             w_issue_block;
   logic             w_word0_ok;

   logic             r_valid;
   logic             r_newblock;
   HashState         r_state;
   logic [CNT_W-1:0] r_gap;

   sha_word_assembler u_assembler (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_accept),
      .i_abort    (abort_i),
      .i_word     (word_i),
      .i_first    (first_i),
      .i_midstate (midstate_i),
      .o_count    (w_count),
      .o_buf      (w_buf),
      .o_last     (w_last),
      .o_first    (w_first),
      .o_midstate (w_mid)
   );

`ifdef SHA_INJECT_DOUBLE_BUFFER_EN
   // The issue cycle only stalls word 0 when a gap is requested.
   assign w_issue_block = (MIN_GAP != 0) & r_valid;
`else
   // The shared buffer is still on W_o during the issue cycle.
   assign w_issue_block = r_valid;
`endif

   // Word 0 waits for the gap to drain; words 1..15 are never gated.
   assign w_word0_ok   = ~w_issue_block & (r_gap == '0);
   assign word_ready_o = ~rst & ((w_count != '0) | w_word0_ok);
   assign w_accept     = word_valid_i & word_ready_o;

   // Issue pulse plus the chaining-state / newblock output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_newblock <= 1'b0;
         r_state    <= SHA256_IV;
      end else begin
         r_valid <= w_last;
         if (w_last) begin
            r_newblock <= w_first;
            if (w_first) begin
               r_state <= w_mid;
            end
         end
      end
   end

   // Gap counter: loaded as the issue pulse ends, counts down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap <= '0;
      end else if (r_valid) begin
         r_gap <= c_GAP_LOAD;
      end else if (r_gap != '0) begin
         r_gap <= r_gap - 4'd1;
      end
   end

`ifdef SHA_INJECT_DOUBLE_BUFFER_EN
   MsgBlock w_block_next;
   MsgBlock r_W;

   // Completed block: stored words plus word 15 arriving this cycle.
   always_comb begin
      w_block_next                  = w_buf;
      w_block_next[BLOCK_WORDS - 1] = word_i;
   end

   // Output block register, refreshed only at issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_W <= '0;
      end else if (w_last) begin
         r_W <= w_block_next;
      end
   end

   assign W_o = r_W;
`else
   assign W_o = w_buf;
`endif

   assign valid_o    = r_valid;
   assign newblock_o = r_newblock;
   assign state_o    = r_state;

endmodule : sha_block_injector
`default_nettype wire
